// File: rtl/enemy_sprite_renderer.sv
// rtl/enemy_sprite_renderer.sv - erases and redraws up to N_PLANES 5x5 enemy sprites into the VGA frame buffer
module enemy_sprite_renderer #(
  parameter int          N_PLANES  = 10,
  parameter int          SCREEN_W  = 160,
  parameter int          SCREEN_H  = 120,
  parameter logic [2:0]  FG_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [8*N_PLANES-1:0] x_in,
  input  logic [8*N_PLANES-1:0] y_in,
  input  logic [N_PLANES-1:0]   vis_in,
  output logic [7:0]            vga_x,
  output logic [6:0]            vga_y,
  output logic [2:0]            vga_colour,
  output logic                  vga_plot,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  localparam logic [3:0] PLANE_LAST = 4'(N_PLANES - 1);

  state_t                r_state;
  logic [3:0]            r_plane;
  logic                  r_phase;   // 0 = erase at old position, 1 = draw at new position
  logic [2:0]            r_dx;
  logic [2:0]            r_dy;
  logic [8*N_PLANES-1:0] r_new_x;
  logic [8*N_PLANES-1:0] r_new_y;
  logic [8*N_PLANES-1:0] r_old_x;
  logic [8*N_PLANES-1:0] r_old_y;
  logic [N_PLANES-1:0]   r_new_vis;
  logic [N_PLANES-1:0]   r_old_vis;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_plane   <= '0;
      r_phase   <= 1'b0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_new_x   <= '0;
      r_new_y   <= '0;
      r_old_x   <= '0;
      r_old_y   <= '0;
      r_new_vis <= '0;
      r_old_vis <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_new_x   <= x_in;
            r_new_y   <= y_in;
            r_new_vis <= vis_in;
            r_plane   <= '0;
            r_phase   <= 1'b0;
            r_dx      <= '0;
            r_dy      <= '0;
            r_state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_dx != 3'd4) begin
            r_dx <= r_dx + 3'd1;
          end else begin
            r_dx <= '0;
            if (r_dy != 3'd4) begin
              r_dy <= r_dy + 3'd1;
            end else begin
              r_dy <= '0;
              if (!r_phase) begin
                r_phase <= 1'b1;
              end else begin
                r_phase <= 1'b0;
                if (r_plane == PLANE_LAST) begin
                  r_plane <= '0;
                  r_state <= S_DONE;
                end else begin
                  r_plane <= r_plane + 4'd1;
                end
              end
            end
          end
        end
        S_DONE: begin
          // What was just drawn becomes what the next frame must erase
          r_old_x   <= r_new_x;
          r_old_y   <= r_new_y;
          r_old_vis <= r_new_vis;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic [7:0] w_base_x;
  logic [7:0] w_base_y;
  logic       w_vis;
  logic [8:0] w_px;
  logic [8:0] w_py;
  logic       w_in_screen;
  logic       w_mask;
  logic       w_scan;

  assign w_base_x    = r_phase ? r_new_x[r_plane*8 +: 8] : r_old_x[r_plane*8 +: 8];
  assign w_base_y    = r_phase ? r_new_y[r_plane*8 +: 8] : r_old_y[r_plane*8 +: 8];
  assign w_vis       = r_phase ? r_new_vis[r_plane] : r_old_vis[r_plane];
  assign w_px        = {1'b0, w_base_x} + {6'b0, r_dx};
  assign w_py        = {1'b0, w_base_y} + {6'b0, r_dy};
  assign w_in_screen = (w_px < 9'(SCREEN_W)) && (w_py < 9'(SCREEN_H));
  assign w_scan      = (r_state == S_SCAN);

  // Sprite shape; erase clears the whole 5x5 box instead
  always_comb begin
    w_mask = 1'b0;
    case (r_dy)
      3'd1:    w_mask = (r_dx == 3'd2);
      3'd2:    w_mask = (r_dx <= 3'd4);
      3'd3:    w_mask = (r_dx == 3'd2);
      3'd4:    w_mask = (r_dx >= 3'd1) && (r_dx <= 3'd3);
      default: w_mask = 1'b0;
    endcase
  end

  assign vga_plot   = w_scan && w_vis && (!r_phase || w_mask) && w_in_screen;
  assign vga_x      = w_scan ? w_px[7:0] : 8'd0;
  assign vga_y      = w_scan ? w_py[6:0] : 7'd0;
  assign vga_colour = (w_scan && r_phase) ? FG_COLOUR : BG_COLOUR;
  assign busy       = w_scan;
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_enemy_sprite_renderer.sv
// tb/tb_enemy_sprite_renderer.sv - scoreboard bench for enemy_sprite_renderer
module tb_enemy_sprite_renderer;

  localparam int N = 10;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [8*N-1:0] x_in = '0;
  logic [8*N-1:0] y_in = '0;
  logic [N-1:0] vis_in = '0;
  logic [7:0]   vga_x;
  logic [6:0]   vga_y;
  logic [2:0]   vga_colour;
  logic         vga_plot;
  logic         busy;
  logic         done;

  enemy_sprite_renderer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .x_in(x_in), .y_in(y_in), .vis_in(vis_in),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int x; int y; int col; int cyc;} pix_t;
  pix_t q[$];

  int n_checks = 0;
  int n_errors = 0;
  int busy_lo = 1;
  int busy_hi = 0;
  int done_at = -1;
  int n_done = 0;
  int n_plots = 0;

  logic [4:0] mask_rows [5] = '{5'b00000, 5'b00100, 5'b11111, 5'b00100, 5'b01110};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_px(input int x, input int y, input int col, input int c);
    pix_t p;
    p.x = x; p.y = y; p.col = col; p.cyc = c;
    q.push_back(p);
  endtask

  task automatic push_erase(input int c0, input int bx, input int by);
    for (int s = 0; s < 25; s++)
      if (bx + s % 5 < 160 && by + s / 5 < 120) push_px(bx + s % 5, by + s / 5, 0, c0 + s);
  endtask

  task automatic push_draw(input int c0, input int bx, input int by);
    logic [4:0] row;
    for (int s = 0; s < 25; s++) begin
      row = mask_rows[s / 5];
      if (row[s % 5] && bx + s % 5 < 160 && by + s / 5 < 120)
        push_px(bx + s % 5, by + s / 5, 7, c0 + s);
    end
  endtask

  // Monitor: per-cycle busy/done windows and in-order pixel scoreboard
  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
      check("done", int'(done), int'(cyc == done_at));
      if (done === 1'b1) n_done++;
      if (vga_plot === 1'b1) begin
        pix_t p;
        n_plots++;
        check("clip", int'(vga_x < 8'd160 && vga_y < 7'd120), 1);
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL pixel: unexpected plot (%0d,%0d) c%0d at cycle %0d, none expected",
                   vga_x, vga_y, vga_colour, cyc);
        end else begin
          p = q.pop_front();
          if (int'(vga_x) != p.x || int'(vga_y) != p.y || int'(vga_colour) != p.col || cyc != p.cyc) begin
            n_errors++;
            $display("FAIL pixel: got (%0d,%0d) c%0d at cycle %0d expected (%0d,%0d) c%0d at cycle %0d",
                     vga_x, vga_y, vga_colour, cyc, p.x, p.y, p.col, p.cyc);
          end
        end
      end
    end
  end

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic open_window(input int t);
    busy_lo = t + 1;
    busy_hi = t + 50 * N;
    done_at = t + 50 * N + 1;
  endtask

  int t;
  int t3;

  initial begin
    // Reset state
    at(3);
    check("rst plot", int'(vga_plot), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst x", int'(vga_x), 0);
    check("rst y", int'(vga_y), 0);
    check("rst colour", int'(vga_colour), 0);
    reset_n = 1'b1;
    at(5);

    // Frame 1: plane0 at (10,20), nothing to erase; stray starts ignored
    vis_in = 10'h001; x_in[7:0] = 8'd10; y_in[7:0] = 8'd20;
    t = cyc; start = 1'b1; open_window(t);
    push_px(12, 21, 7, t + 33);
    push_px(10, 22, 7, t + 36); push_px(11, 22, 7, t + 37); push_px(12, 22, 7, t + 38);
    push_px(13, 22, 7, t + 39); push_px(14, 22, 7, t + 40);
    push_px(12, 23, 7, t + 43);
    push_px(11, 24, 7, t + 47); push_px(12, 24, 7, t + 48); push_px(13, 24, 7, t + 49);
    at(t + 1);   start = 1'b0;
    at(t + 100); start = 1'b1;
    at(t + 101); start = 1'b0;
    at(t + 501); start = 1'b1;
    at(t + 502); start = 1'b0;
    at(t + 520);
    check("f1 drained", q.size(), 0);
    check("f1 done pulses", n_done, 1);

    // Frame 2: move to (10,22); inputs changed mid-scan; start held through done
    x_in[7:0] = 8'd10; y_in[7:0] = 8'd22;
    t = cyc; start = 1'b1; open_window(t);
    push_erase(t + 1, 10, 20);
    push_draw(t + 26, 10, 22);
    at(t + 10); x_in[7:0] = 8'd157; y_in[7:0] = 8'd117;
    at(t + 502);
    check("f2 drained", q.size(), 0);

    // Frame 3: accepted on first IDLE cycle, clipped at (157,117)
    t3 = cyc; open_window(t3);
    push_erase(t3 + 1, 10, 22);
    push_px(159, 118, 7, t3 + 33);
    push_px(157, 119, 7, t3 + 36); push_px(158, 119, 7, t3 + 37); push_px(159, 119, 7, t3 + 38);
    at(t3 + 1); start = 1'b0;
    at(t3 + 520);
    check("f3 drained", q.size(), 0);
    check("f3 done pulses", n_done, 3);

    // Frame 4: all planes visible, reset during plane1
    for (int i = 0; i < N; i++) begin
      x_in[8*i +: 8] = 8'(20 + 12 * i);
      y_in[8*i +: 8] = 8'd50;
    end
    vis_in = 10'h3FF;
    t = cyc; start = 1'b1; open_window(t);
    push_erase(t + 1, 157, 117);
    push_draw(t + 26, 20, 50);
    push_draw(t + 76, 32, 50);
    at(t + 1); start = 1'b0;
    at(t + 100); reset_n = 1'b0; busy_hi = t + 100; done_at = -1;
    at(t + 101);
    check("midrst plot", int'(vga_plot), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    reset_n = 1'b1;
    at(t + 110);
    check("f4 drained", q.size(), 0);

    // Frame 5: nothing erased after reset, 100 draw plots
    n_plots = 0;
    t = cyc; start = 1'b1; open_window(t);
    for (int i = 0; i < N; i++) push_draw(t + 26 + 50 * i, 20 + 12 * i, 50);
    at(t + 1); start = 1'b0;
    at(t + 520);
    check("f5 plots", n_plots, 100);
    check("f5 drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
